// File: rtl/fe_fetch_queue_pkg.sv
// Shared types and defaults for the front-end fetch queue.
//   FE_WORD_SIZE   : default width of PC, ROM address and instruction
//   FE_QUEUE_DEPTH : default number of queue entries
//   fe_entry_t     : one queued {pc, instr} pair at the default width
package Purple_Jade_pkg;

  localparam int FE_WORD_SIZE   = 16;
  localparam int FE_QUEUE_DEPTH = 4;

  typedef struct packed {
    logic [FE_WORD_SIZE-1:0] pc;
    logic [FE_WORD_SIZE-1:0] instr;
  } fe_entry_t;

endpackage

// File: rtl/fe_instr_fifo.sv
// Circular buffer holding fetched {pc, instr} entries.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   flush_i          : empty the buffer (wins over enq_i/deq_i)
//   enq_i/enq_data_i : write one entry at the tail
//   deq_i            : retire the head entry (only asserted when non-empty)
//   head_data_o      : entry at the head
//   full_o, count_o  : occupancy
module fe_instr_fifo #(
  parameter int DEPTH_P  = 4,
  parameter int DATA_W_P = 32
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         flush_i,
  input  logic                         enq_i,
  input  logic [DATA_W_P-1:0]          enq_data_i,
  input  logic                         deq_i,
  output logic [DATA_W_P-1:0]          head_data_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH_P+1)-1:0] count_o
);

  localparam int PTR_W = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
  localparam int CNT_W = $clog2(DEPTH_P+1);

  logic [DATA_W_P-1:0] mem [DEPTH_P];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  // Power-of-two depth lets the pointer wrap by overflow; a single entry
  // has no pointer bits to speak of, so it stays at zero.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (DEPTH_P == 1) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned -- otherwise synthesis infers a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (deq_i) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(enq_i) - CNT_W'(deq_i);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count_q alone
  // decides which entries are meaningful, and a reset-free array maps to RAM.
  always_ff @(posedge clk_i) begin
    if (enq_i && !flush_i) mem[wr_ptr_q] <= enq_data_i;
  end

  assign head_data_o = mem[rd_ptr_q];
  assign full_o      = (count_q == CNT_W'(DEPTH_P));
  assign count_o     = count_q;

endmodule

// File: rtl/fe_fetch_queue.sv
// Fetch stage: owns the PC, reads the combinational instruction ROM and
// buffers {pc, instr} pairs so decode backpressure never stalls the PC
// combinationally. A redirect flushes the buffer and retargets fetch.
//   clk_i, reset_n_i             : clock, asynchronous active-low reset
//   redirect_v_i, redirect_pc_i  : flush and new fetch target
//   i_rom_r_addr_o, i_rom_data_i : ROM address (== PC) and same-cycle data
//   deq_ready_i                  : consumer takes the head entry
//   deq_v_o, deq_pc_o, deq_instr_o : head entry
//   count_o                      : occupied entries
module fe_fetch_queue
  import Purple_Jade_pkg::*;
#(
  parameter int                     WORD_SIZE_P = FE_WORD_SIZE,
  parameter int                     DEPTH_P     = FE_QUEUE_DEPTH,
  parameter logic [WORD_SIZE_P-1:0] RESET_PC_P  = '0
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         redirect_v_i,
  input  logic [WORD_SIZE_P-1:0]       redirect_pc_i,
  output logic [WORD_SIZE_P-1:0]       i_rom_r_addr_o,
  input  logic [WORD_SIZE_P-1:0]       i_rom_data_i,
  input  logic                         deq_ready_i,
  output logic                         deq_v_o,
  output logic [WORD_SIZE_P-1:0]       deq_pc_o,
  output logic [WORD_SIZE_P-1:0]       deq_instr_o,
  output logic [$clog2(DEPTH_P+1)-1:0] count_o
);

  logic [WORD_SIZE_P-1:0]   pc_q, pc_d;
  logic                     full;
  logic                     deq_fire;
  logic                     enq_fire;
  logic [2*WORD_SIZE_P-1:0] head_data;

  // A full queue still accepts a new entry when the head leaves in the
  // same cycle, which keeps throughput at one per cycle even at depth 1.
  assign deq_fire = deq_v_o & deq_ready_i;
  assign enq_fire = ~redirect_v_i & (~full | deq_fire);

  always_comb begin
    pc_d = pc_q;
    if (redirect_v_i)  pc_d = redirect_pc_i;
    else if (enq_fire) pc_d = pc_q + WORD_SIZE_P'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) pc_q <= RESET_PC_P;
    else            pc_q <= pc_d;
  end

  fe_instr_fifo #(
    .DEPTH_P  (DEPTH_P),
    .DATA_W_P (2*WORD_SIZE_P)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .flush_i     (redirect_v_i),
    .enq_i       (enq_fire),
    .enq_data_i  ({pc_q, i_rom_data_i}),
    .deq_i       (deq_fire),
    .head_data_o (head_data),
    .full_o      (full),
    .count_o     (count_o)
  );

  assign i_rom_r_addr_o           = pc_q;
  assign deq_v_o                  = (count_o != '0);
  assign {deq_pc_o, deq_instr_o}  = head_data;

endmodule

// File: tb/tb_fe_fetch_queue.sv
// Randomised scoreboard bench for fe_fetch_queue (DEPTH_P=4, 16-bit words),
// plus a second instance started at 0xFFFE to observe PC wrap.
module tb_fe_fetch_queue;
  import Purple_Jade_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_v = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] rom_addr, rom_data;
  logic        deq_ready = 1'b0;
  logic        deq_v;
  logic [15:0] deq_pc, deq_instr;
  logic [2:0]  count;

  logic        wrap_ready = 1'b0;
  logic [15:0] wrap_addr, wrap_data;
  logic        wrap_v;
  logic [15:0] wrap_pc, wrap_instr;
  logic [2:0]  wrap_count;

  always #5 clk = ~clk;

  // ROM contents: word i holds 0xA000 + i (16-bit arithmetic).
  function automatic logic [15:0] rom(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  assign rom_data  = rom(rom_addr);
  assign wrap_data = rom(wrap_addr);

  fe_fetch_queue #(.WORD_SIZE_P(16), .DEPTH_P(DEPTH), .RESET_PC_P(16'h0000)) dut (
    .clk_i          (clk),
    .reset_n_i      (rst_n),
    .redirect_v_i   (redirect_v),
    .redirect_pc_i  (redirect_pc),
    .i_rom_r_addr_o (rom_addr),
    .i_rom_data_i   (rom_data),
    .deq_ready_i    (deq_ready),
    .deq_v_o        (deq_v),
    .deq_pc_o       (deq_pc),
    .deq_instr_o    (deq_instr),
    .count_o        (count)
  );

  fe_fetch_queue #(.WORD_SIZE_P(16), .DEPTH_P(DEPTH), .RESET_PC_P(16'hFFFE)) u_wrap (
    .clk_i          (clk),
    .reset_n_i      (rst_n),
    .redirect_v_i   (1'b0),
    .redirect_pc_i  (16'h0000),
    .i_rom_r_addr_o (wrap_addr),
    .i_rom_data_i   (wrap_data),
    .deq_ready_i    (wrap_ready),
    .deq_v_o        (wrap_v),
    .deq_pc_o       (wrap_pc),
    .deq_instr_o    (wrap_instr),
    .count_o        (wrap_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue contents and the fetch PC.
  fe_entry_t   mq[$];
  logic [15:0] m_pc;

  // Scoreboard: expectations per cycle, consumed by the monitor.
  fe_entry_t   sb_deq[$];
  logic [2:0]  sb_cnt[$];
  logic [15:0] sb_pc[$];

  // One clock cycle of stimulus. Called just after a rising edge; drives the
  // inputs, posts what the DUT must show this cycle, then advances the model
  // across the next edge.
  task automatic step(input bit ready, input bit redir, input logic [15:0] tgt);
    fe_entry_t e;
    deq_ready   = ready;
    redirect_v  = redir;
    redirect_pc = tgt;
    sb_cnt.push_back(3'(mq.size()));
    sb_pc.push_back(m_pc);
    if (ready && mq.size() != 0) sb_deq.push_back(mq[0]);
    @(posedge clk);
    #1;
    if (ready && mq.size() != 0) void'(mq.pop_front());
    if (redir) begin
      mq.delete();
      m_pc = tgt;
    end else if (mq.size() < DEPTH) begin
      e.pc    = m_pc;
      e.instr = rom(m_pc);
      mq.push_back(e);
      m_pc = m_pc + 16'd1;
    end
  endtask

  // Monitor: compares observable outputs mid-cycle against the scoreboard.
  logic [2:0] mon_cnt;
  fe_entry_t  mon_e;
  bit         mon_exp_fire;
  always @(negedge clk) begin
    if (sb_cnt.size() != 0) begin
      mon_cnt = sb_cnt.pop_front();
      check("count_o", 32'(count), 32'(mon_cnt));
      check("deq_v_o", 32'(deq_v), 32'(mon_cnt != 0));
      check("rom_addr", 32'(rom_addr), 32'(sb_pc.pop_front()));
      mon_exp_fire = (sb_deq.size() != 0);
      check("deq_fire", 32'(deq_v & deq_ready), 32'(mon_exp_fire));
      if (mon_exp_fire) begin
        mon_e = sb_deq.pop_front();
        if (deq_v & deq_ready) begin
          check("deq_pc", 32'(deq_pc), 32'(mon_e.pc));
          check("deq_instr", 32'(deq_instr), 32'(mon_e.instr));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] wrap_exp [3];

  initial begin
    // Reset state
    #12;
    check("rst_deq_v", 32'(deq_v), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'h0000);
    check("rst_wrap_addr", 32'(wrap_addr), 32'hFFFE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    m_pc = 16'h0000;

    // Streaming with the consumer always ready: no bubbles.
    repeat (10) step(1'b1, 1'b0, '0);

    // Fill from PC 0 with the consumer stalled, then drain in order.
    step(1'b0, 1'b1, 16'h0000);
    repeat (8) step(1'b0, 1'b0, '0);
    check("fill_addr_hold", 32'(rom_addr), 32'h0004);
    check("fill_count", 32'(count), 32'd4);
    repeat (6) step(1'b1, 1'b0, '0);

    // Random backpressure across several pointer wraps.
    repeat (40) step(1'($urandom_range(0, 99) < 60), 1'b0, '0);

    // Redirect while full and the consumer ready.
    repeat (6) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 16'h0100);
    repeat (4) step(1'b1, 1'b0, '0);

    // Random backpressure mixed with random redirects.
    repeat (60)
      step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 9) == 0),
           16'($urandom_range(0, 16'hFFFF)));

    // Asynchronous reset between edges with 3 entries queued.
    step(1'b0, 1'b1, 16'h0020);
    repeat (3) step(1'b0, 1'b0, '0);
    check("pre_reset_count", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_deq_v", 32'(deq_v), 32'd0);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_addr", 32'(rom_addr), 32'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    m_pc = 16'h0000;
    repeat (6) step(1'b1, 1'b0, '0);

    // PC wrap on the instance reset to 0xFFFE (filled while stalled).
    deq_ready  = 1'b0;
    wrap_ready = 1'b1;
    wrap_exp[0] = 16'hFFFE;
    wrap_exp[1] = 16'hFFFF;
    wrap_exp[2] = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wrap_v", 32'(wrap_v), 32'd1);
      check("wrap_pc", 32'(wrap_pc), 32'(wrap_exp[i]));
      check("wrap_instr", 32'(wrap_instr), 32'(rom(wrap_exp[i])));
    end

    @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fe_fetch_queue.md
# fe_fetch_queue

Parametrised fetch stage with a decoupling instruction queue. It generates the PC, reads the instruction ROM, and buffers up to DEPTH_P {pc, instruction} entries, so decode backpressure no longer stalls the PC combinationally. It sits between the i_rom and the decode stage of the front end. A redirect input, driven by the branch stage or by a back-end mispredict, flushes the queue and retargets fetch.

## Interface
Parameters:
- WORD_SIZE_P, 16, width of PC, ROM address and instruction
- DEPTH_P, 4, queue entries; must be a power of two, ≥1
- RESET_PC_P, 0, PC value loaded on reset

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous, active-low
- redirect_v_i  in  1  flush the queue and retarget fetch
- redirect_pc_i  in  WORD_SIZE_P  redirect target
- i_rom_r_addr_o  out  WORD_SIZE_P  ROM read address (combinational ROM, same-cycle data)
- i_rom_data_i  in  WORD_SIZE_P  ROM read data
- deq_ready_i  in  1  consumer accepts the head entry
- deq_v_o  out  1  head entry valid
- deq_pc_o  out  WORD_SIZE_P  head PC
- deq_instr_o  out  WORD_SIZE_P  head instruction
- count_o  out  $clog2(DEPTH_P+1)  occupied entries

## Operation
- State: pc_r, rd_ptr, wr_ptr (each log2(DEPTH_P) bits, wrap naturally), count_r, storage[DEPTH_P].
- i_rom_r_addr_o = pc_r at all times.
- deq fire = deq_v_o & deq_ready_i. deq_v_o = (count_r != 0). Head outputs come from storage[rd_ptr].
- enq fire = ~redirect_v_i & (count_r < DEPTH_P | deq fire). On enq fire:
  - write {pc_r, i_rom_data_i} at wr_ptr
  - wr_ptr += 1
  - pc_r <= pc_r + 1, modulo 2^WORD_SIZE_P
- When there is no enq fire and no redirect, pc_r holds.
- count_r next = count_r + enq − deq. Full with a simultaneous deq gives enq and deq, and count is unchanged.
- Redirect takes priority over everything:
  - rd_ptr = wr_ptr = count_r = 0
  - pc_r <= redirect_pc_i
  - no enqueue that cycle
  - A deq fire in the same cycle still counts as consumed by the receiver. Discarding it is the consumer's responsibility, since the redirect source knows ordering.
- deq_ready_i while empty has no effect. No overflow or underflow can occur by construction.
- Reset values: pc_r = RESET_PC_P, pointers and count = 0, deq_v_o = 0, count_o = 0, i_rom_r_addr_o = RESET_PC_P. Storage is not reset.
- Reset asserted mid-operation immediately empties the queue and deq_v_o drops asynchronously.

## Timing
- Fetch-to-valid: an instruction read in cycle N is visible at the queue head in cycle N+1 if the queue was empty. There is no bypass path.
- Redirect asserted in cycle N:
  - the target is read in N+1
  - deq_v_o rises in N+2 with deq_pc_o = target
- Sustained throughput is one entry per cycle while deq_ready_i stays high, for every DEPTH_P ≥ 1.
- With deq_ready_i low, the queue fills in DEPTH_P cycles and pc_r then stops at fill start + DEPTH_P.
- Inputs redirect_v_i, redirect_pc_i and deq_ready_i are sampled at the rising edge. There are no combinational in-to-out paths except the ROM address and data loop.

## Structure
- In Purple_Jade_pkg: fe_entry_t packed struct {pc, instr}, plus FE_QUEUE_DEPTH default constant.
- One sub-module, fe_instr_fifo: the storage, the pointers and the count, with enq, deq and flush ports.
- The PC logic and redirect priority stay in fe_fetch_queue.

## Test plan
- Reset release, deq_ready_i=1, ROM[i]=0xA000+i → from cycle 2, deq_pc_o = 0,1,2… and deq_instr_o = 0xA000,0xA001… every cycle, with no bubbles.
- DEPTH_P=4, deq_ready_i=0 for 8 cycles:
  - count_o saturates at 4 and i_rom_r_addr_o holds at 4
  - after releasing deq_ready_i, PCs 0–3 then 4 dequeue in order
- Wrap-around: 3×DEPTH_P entries with random deq_ready_i → order is preserved across pointer wrap, and count_o always equals enqueued minus dequeued.
- Redirect to 0x0100 while full and deq_ready_i=1:
  - next cycle count_o=0, deq_v_o=0
  - one cycle later deq_pc_o=0x0100
- PC wrap at RESET_PC_P=0xFFFE → PCs 0xFFFE, 0xFFFF, 0x0000 are enqueued.
- reset_n_i pulsed low between clock edges with 3 entries queued → deq_v_o=0 and count_o=0 immediately; after release fetch resumes at RESET_PC_P.
